pipe_hazard_ctrl: RTL and testbench

//   Parametrised pipeline control unit for the RISC core. Tracks in-flight register

---
 rtl/pipe_hazard_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard-unit port bundle: ID operand/dest info and pipe control outputs.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_aa;
  logic              id_a_use;
  logic [REG_AW-1:0] id_ba;
  logic              id_b_use;
  logic              id_rw;
  logic [REG_AW-1:0] id_da;
  logic              id_load;
  logic              ex_br_taken;
  logic              mem_ready;
  logic [2:0]        fwd_sel_a;
  logic [2:0]        fwd_sel_b;
  logic              stall;
  logic              bubble_ex;
  logic              flush_id;
  logic              freeze;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_aa, id_a_use, id_ba, id_b_use,
    output id_rw, id_da, id_load, ex_br_taken, mem_ready,
    input  fwd_sel_a, fwd_sel_b, stall, bubble_ex,
    input  flush_id, freeze, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_aa, id_a_use, id_ba, id_b_use,
    input  id_rw, id_da, id_load, ex_br_taken, mem_ready,
    output fwd_sel_a, fwd_sel_b, stall, bubble_ex,
    output flush_id, freeze, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: writer scoreboard, forwarding selects,
// load-use stalls, branch-shadow flushes and memory-wait freezes.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_RDY  = 2,
  parameter int BR_SHADOW = 2,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_hazard_if.slave  hz
);

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [REG_AW-1:0] da;
    logic              load;
  } sb_t;

  sb_t             sb_q [1:FWD_DEPTH];
  sb_t             sb_d [1:FWD_DEPTH];
  logic [1:0]      shd_q, shd_d;
  logic            fl_hold_q, fl_hold_d;
  logic            bub_hold_q, bub_hold_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  int   ka, kb;
  logic lda, ldb;
  logic lu_a, lu_b;
  logic br_now;
  logic stall_run;
  logic frz;

  function automatic logic hit(sb_t e, logic [REG_AW-1:0] a,
                               logic use_x);
    return use_x & e.valid & e.rw & (e.da == a) & (a != '0);
  endfunction

  // Scan oldest to youngest so the youngest match is left standing.
  always_comb begin
    ka  = 0;
    kb  = 0;
    lda = 1'b0;
    ldb = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit(sb_q[k], hz.id_aa, hz.id_a_use)) begin
        ka  = k;
        lda = sb_q[k].load;
      end
      if (hit(sb_q[k], hz.id_ba, hz.id_b_use)) begin
        kb  = k;
        ldb = sb_q[k].load;
      end
    end
  end

  assign lu_a = lda & (ka != 0) & (ka < LOAD_RDY);
  assign lu_b = ldb & (kb != 0) & (kb < LOAD_RDY);

  assign br_now    = hz.ex_br_taken | (shd_q != 2'd0);
  assign stall_run = (lu_a | lu_b) & ~br_now;
  assign frz       = rst_n & ~hz.mem_ready;

  assign hz.fwd_sel_a = lu_a ? 3'd0 : 3'(ka);
  assign hz.fwd_sel_b = lu_b ? 3'd0 : 3'(kb);
  assign hz.freeze    = frz;
  assign hz.stall     = rst_n & (frz | stall_run);
  assign hz.bubble_ex = rst_n & (frz ? bub_hold_q : stall_run);
  assign hz.flush_id  = ~rst_n | (frz ? fl_hold_q : br_now);
  assign hz.stall_cnt = scnt_q;
  assign hz.flush_cnt = fcnt_q;

  always_comb begin
    sb_d       = sb_q;
    shd_d      = shd_q;
    fl_hold_d  = fl_hold_q;
    bub_hold_d = bub_hold_q;
    scnt_d     = scnt_q;
    fcnt_d     = fcnt_q;
    if (hz.mem_ready) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[1].valid = hz.id_valid & ~stall_run & ~br_now;
      sb_d[1].rw    = hz.id_rw;
      sb_d[1].da    = hz.id_da;
      sb_d[1].load  = hz.id_load;
      if (hz.ex_br_taken) begin
        shd_d = 2'(BR_SHADOW - 1);
      end else if (shd_q != 2'd0) begin
        shd_d = shd_q - 2'd1;
      end
      fl_hold_d  = br_now;
      bub_hold_d = stall_run;
      if (hz.ex_br_taken && fcnt_q != '1) begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    if ((frz | stall_run) && scnt_q != '1) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      shd_q      <= 2'd0;
      fl_hold_q  <= 1'b1;
      bub_hold_q <= 1'b0;
      scnt_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      sb_q       <= sb_d;
      shd_q      <= shd_d;
      fl_hold_q  <= fl_hold_d;
      bub_hold_q <= bub_hold_d;
      scnt_q     <= scnt_d;
      fcnt_q     <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters
// (FWD_DEPTH=2, LOAD_RDY=2, BR_SHADOW=2, CNT_W=16).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  pipe_hazard_if #(.REG_AW(5), .CNT_W(16)) hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_valid = 0; hz.id_aa = 0; hz.id_a_use = 0;
    hz.id_ba = 0; hz.id_b_use = 0; hz.id_rw = 0;
    hz.id_da = 0; hz.id_load = 0;
    hz.ex_br_taken = 0; hz.mem_ready = 1;
  endtask

  task automatic instr(input logic [4:0] aa, input logic au,
                       input logic [4:0] ba, input logic bu,
                       input logic rw, input logic [4:0] da,
                       input logic ld);
    hz.id_valid = 1; hz.id_aa = aa; hz.id_a_use = au;
    hz.id_ba = ba; hz.id_b_use = bu; hz.id_rw = rw;
    hz.id_da = da; hz.id_load = ld;
  endtask

  task automatic test_reset();
    rst_n = 0;
    instr(5'd1, 1, 5'd1, 1, 1, 5'd1, 1);
    hz.ex_br_taken = 0; hz.mem_ready = 0;
    #2;
    checks++; if (hz.flush_id !== 1'b1) begin errors++; $display("FAIL rst_flush got %b exp 1", hz.flush_id); end
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", hz.stall); end
    checks++; if (hz.freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got %b exp 0", hz.freeze); end
    checks++; if (hz.bubble_ex !== 1'b0) begin errors++; $display("FAIL rst_bubble got %b exp 0", hz.bubble_ex); end
    checks++; if (hz.fwd_sel_a !== 3'd0) begin errors++; $display("FAIL rst_fwd_a got %0d exp 0", hz.fwd_sel_a); end
    checks++; if (hz.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_scnt got %0d exp 0", hz.stall_cnt); end
    checks++; if (hz.flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_fcnt got %0d exp 0", hz.flush_cnt); end
    @(negedge clk);
    rst_n = 1;
    idle();
    tick();
    checks++; if (hz.flush_id !== 1'b0) begin errors++; $display("FAIL post_rst_flush got %b exp 0", hz.flush_id); end
  endtask

  task automatic test_back_to_back();
    instr(5'd1, 1, 5'd2, 1, 1, 5'd3, 0);
    @(negedge clk);
    checks++; if (hz.fwd_sel_a !== 3'd0) begin errors++; $display("FAIL b2b_first_a got %0d exp 0", hz.fwd_sel_a); end
    tick();
    instr(5'd3, 1, 5'd3, 1, 1, 5'd4, 0);
    @(negedge clk);
    checks++; if (hz.fwd_sel_a !== 3'd1) begin errors++; $display("FAIL b2b_fwd_a got %0d exp 1", hz.fwd_sel_a); end
    checks++; if (hz.fwd_sel_b !== 3'd1) begin errors++; $display("FAIL b2b_fwd_b got %0d exp 1", hz.fwd_sel_b); end
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", hz.stall); end
    tick();
    idle(); tick(); tick();
  endtask

  task automatic test_load_use();
    instr(5'd0, 0, 5'd0, 0, 1, 5'd5, 1);
    tick();
    instr(5'd5, 1, 5'd0, 1, 1, 5'd6, 0);
    @(negedge clk);
    checks++; if (hz.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", hz.stall); end
    checks++; if (hz.bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_bubble got %b exp 1", hz.bubble_ex); end
    checks++; if (hz.fwd_sel_a !== 3'd0) begin errors++; $display("FAIL lu_fwd_a got %0d exp 0", hz.fwd_sel_a); end
    checks++; if (hz.fwd_sel_b !== 3'd0) begin errors++; $display("FAIL lu_fwd_b got %0d exp 0", hz.fwd_sel_b); end
    tick();
    @(negedge clk);
    checks++; if (hz.fwd_sel_a !== 3'd2) begin errors++; $display("FAIL lu_next_fwd_a got %0d exp 2", hz.fwd_sel_a); end
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL lu_next_stall got %b exp 0", hz.stall); end
    checks++; if (hz.bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_next_bubble got %b exp 0", hz.bubble_ex); end
    checks++; if (hz.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_scnt got %0d exp 1", hz.stall_cnt); end
    tick();
    idle(); tick(); tick();
  endtask

  task automatic test_youngest();
    instr(5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
    tick();
    instr(5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
    tick();
    instr(5'd7, 1, 5'd0, 1, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (hz.fwd_sel_a !== 3'd1) begin errors++; $display("FAIL yng_fwd_a got %0d exp 1", hz.fwd_sel_a); end
    checks++; if (hz.fwd_sel_b !== 3'd0) begin errors++; $display("FAIL yng_r0_b got %0d exp 0", hz.fwd_sel_b); end
    hz.id_a_use = 0;
    #1;
    checks++; if (hz.fwd_sel_a !== 3'd0) begin errors++; $display("FAIL yng_nouse_a got %0d exp 0", hz.fwd_sel_a); end
    idle(); tick(); tick();
  endtask

  task automatic test_branch();
    instr(5'd0, 0, 5'd0, 0, 1, 5'd5, 1);
    tick();
    instr(5'd5, 1, 5'd0, 0, 1, 5'd6, 0);
    hz.ex_br_taken = 1;
    @(negedge clk);
    checks++; if (hz.flush_id !== 1'b1) begin errors++; $display("FAIL br_flush0 got %b exp 1", hz.flush_id); end
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL br_lu_stall got %b exp 0", hz.stall); end
    checks++; if (hz.bubble_ex !== 1'b0) begin errors++; $display("FAIL br_lu_bubble got %b exp 0", hz.bubble_ex); end
    tick();
    hz.ex_br_taken = 0;
    @(negedge clk);
    checks++; if (hz.flush_id !== 1'b1) begin errors++; $display("FAIL br_flush1 got %b exp 1", hz.flush_id); end
    checks++; if (hz.flush_cnt !== 16'd1) begin errors++; $display("FAIL br_fcnt got %0d exp 1", hz.flush_cnt); end
    checks++; if (hz.fwd_sel_a !== 3'd2) begin errors++; $display("FAIL br_fwd_a got %0d exp 2", hz.fwd_sel_a); end
    tick();
    @(negedge clk);
    checks++; if (hz.flush_id !== 1'b0) begin errors++; $display("FAIL br_flush2 got %b exp 0", hz.flush_id); end
    checks++; if (hz.stall_cnt !== 16'd1) begin errors++; $display("FAIL br_scnt got %0d exp 1", hz.stall_cnt); end
    idle(); tick(); tick();
  endtask

  task automatic test_freeze();
    instr(5'd0, 0, 5'd0, 0, 1, 5'd3, 0);
    tick();
    instr(5'd3, 1, 5'd0, 0, 1, 5'd8, 0);
    hz.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      hz.ex_br_taken = (i == 2);
      @(negedge clk);
      checks++; if (hz.freeze !== 1'b1) begin errors++; $display("FAIL frz_freeze%0d got %b exp 1", i, hz.freeze); end
      checks++; if (hz.stall !== 1'b1) begin errors++; $display("FAIL frz_stall%0d got %b exp 1", i, hz.stall); end
      checks++; if (hz.fwd_sel_a !== 3'd1) begin errors++; $display("FAIL frz_fwd_a%0d got %0d exp 1", i, hz.fwd_sel_a); end
      checks++; if (hz.flush_id !== 1'b0) begin errors++; $display("FAIL frz_flush%0d got %b exp 0", i, hz.flush_id); end
      checks++; if (hz.bubble_ex !== 1'b0) begin errors++; $display("FAIL frz_bubble%0d got %b exp 0", i, hz.bubble_ex); end
      tick();
    end
    hz.mem_ready = 1;
    @(negedge clk);
    checks++; if (hz.stall_cnt !== 16'd4) begin errors++; $display("FAIL frz_scnt got %0d exp 4", hz.stall_cnt); end
    checks++; if (hz.flush_cnt !== 16'd1) begin errors++; $display("FAIL frz_fcnt_hold got %0d exp 1", hz.flush_cnt); end
    checks++; if (hz.freeze !== 1'b0) begin errors++; $display("FAIL unfrz_freeze got %b exp 0", hz.freeze); end
    checks++; if (hz.fwd_sel_a !== 3'd1) begin errors++; $display("FAIL unfrz_fwd_a got %0d exp 1", hz.fwd_sel_a); end
    checks++; if (hz.flush_id !== 1'b1) begin errors++; $display("FAIL unfrz_br_flush got %b exp 1", hz.flush_id); end
    tick();
    hz.ex_br_taken = 0;
    @(negedge clk);
    checks++; if (hz.flush_cnt !== 16'd2) begin errors++; $display("FAIL unfrz_fcnt got %0d exp 2", hz.flush_cnt); end
    checks++; if (hz.flush_id !== 1'b1) begin errors++; $display("FAIL unfrz_flush1 got %b exp 1", hz.flush_id); end
    tick();
    @(negedge clk);
    checks++; if (hz.flush_id !== 1'b0) begin errors++; $display("FAIL unfrz_flush2 got %b exp 0", hz.flush_id); end
    idle(); tick(); tick();
  endtask

  task automatic test_saturate_reset();
    idle();
    hz.mem_ready = 0;
    repeat (70000) tick();
    @(negedge clk);
    checks++; if (hz.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_scnt got %h exp ffff", hz.stall_cnt); end
    checks++; if (hz.freeze !== 1'b1) begin errors++; $display("FAIL sat_freeze got %b exp 1", hz.freeze); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (hz.flush_id !== 1'b1) begin errors++; $display("FAIL mid_rst_flush got %b exp 1", hz.flush_id); end
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %b exp 0", hz.stall); end
    checks++; if (hz.freeze !== 1'b0) begin errors++; $display("FAIL mid_rst_freeze got %b exp 0", hz.freeze); end
    checks++; if (hz.stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_scnt got %h exp 0", hz.stall_cnt); end
    checks++; if (hz.flush_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_fcnt got %h exp 0", hz.flush_cnt); end
    @(negedge clk);
    rst_n = 1;
    hz.mem_ready = 1;
    tick();
    @(negedge clk);
    checks++; if (hz.stall_cnt !== 16'd0) begin errors++; $display("FAIL after_rst_scnt got %h exp 0", hz.stall_cnt); end
    checks++; if (hz.flush_id !== 1'b0) begin errors++; $display("FAIL after_rst_flush got %b exp 0", hz.flush_id); end
  endtask

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_branch();
    test_freeze();
    test_saturate_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
